vga_pattern_ctrl: RTL and testbench

Test-pattern sequencer for the VGA pixel generator. It selects which pattern the pixel-colour stage draws: colour bars, solid colours, grid or checker. Pattern changes happen only at frame boundaries, so no frame is torn. Changes come from a manual next-pattern key or from an automatic frame-count timer. It sits between the key debouncers and the pixel-data module, and runs on the VGA pixel clock alongside the timing driver.

---
 rtl/vga_pattern_ctrl_if.sv | 20 ++
 rtl/vga_pattern_ctrl.sv | 85 ++++++++
 tb/tb_vga_pattern_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_ctrl_if.sv
// Bundle between the line timing/key front end and the pattern sequencer.
// The master side drives line position and key pulses; the slave returns pattern state.
interface vga_pattern_ctrl_if;
  logic [9:0] pixel_ypos;
  logic       key_next;
  logic       key_mode;
  logic [2:0] pat_sel;
  logic       auto_en;
  logic       frame_end;

  modport master (
    output pixel_ypos, key_next, key_mode,
    input  pat_sel, auto_en, frame_end
  );

  modport slave (
    input  pixel_ypos, key_next, key_mode,
    output pat_sel, auto_en, frame_end
  );
endinterface

// File: rtl/vga_pattern_ctrl.sv
// Test-pattern sequencer: picks the pattern for the pixel stage and only changes it
// at frame boundaries, driven by a next-pattern key or an automatic frame timer.
module vga_pattern_ctrl #(
  parameter logic [9:0]  V_DISP      = 10'd480,
  parameter int          NUM_PAT     = 8,
  parameter logic [11:0] AUTO_FRAMES = 12'd120,
  parameter logic [2:0]  INIT_PAT    = 3'd0
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  vga_pattern_ctrl_if.slave bus
);

  localparam logic [2:0]  LAST_PAT   = 3'(NUM_PAT - 1);
  localparam logic [9:0]  LAST_LINE  = V_DISP - 10'd1;
  localparam logic [11:0] LAST_FRAME = AUTO_FRAMES - 12'd1;

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

  state_t      state;
  logic [9:0]  y_d;
  logic        pending;
  logic [11:0] frame_cnt;
  logic [2:0]  pat_sel;
  logic        auto_en;
  logic        frame_end;

  logic        fe_det;
  logic        req;
  logic        auto_expire;
  logic        advance;

  function automatic logic [2:0] next_pat(input logic [2:0] cur);
    return (cur == LAST_PAT) ? 3'd0 : cur + 3'd1;
  endfunction

  // A key arriving in the boundary cycle itself counts as pending for that boundary.
  assign fe_det      = (y_d == LAST_LINE) && (bus.pixel_ypos == 10'd0);
  assign req         = pending | bus.key_next;
  assign auto_expire = (frame_cnt == LAST_FRAME);
  assign advance     = fe_det && (req || ((state == AUTO) && auto_expire));

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= MANUAL;
      y_d       <= 10'd0;
      pending   <= 1'b0;
      frame_cnt <= 12'd0;
      pat_sel   <= INIT_PAT;
      auto_en   <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      y_d       <= bus.pixel_ypos;
      frame_end <= fe_det;

      if (advance) begin
        pat_sel <= next_pat(pat_sel);
        pending <= 1'b0;
      end else if (bus.key_next) begin
        pending <= 1'b1;
      end

      // The boundary is judged on the pre-toggle state; a mode toggle then restarts the timer.
      if (bus.key_mode) begin
        state     <= (state == MANUAL) ? AUTO : MANUAL;
        auto_en   <= (state == MANUAL);
        frame_cnt <= 12'd0;
      end else begin
        case (state)
          MANUAL: frame_cnt <= 12'd0;
          AUTO: begin
            if (fe_det)
              frame_cnt <= advance ? 12'd0 : frame_cnt + 12'd1;
          end
          default: frame_cnt <= 12'd0;
        endcase
      end
    end
  end

  assign bus.pat_sel   = pat_sel;
  assign bus.auto_en   = auto_en;
  assign bus.frame_end = frame_end;

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Directed bench for the pattern sequencer: full-height frames with short lines,
// boundary results queued when the boundary is driven and checked when frame_end appears.
module tb_vga_pattern_ctrl;

  localparam int H  = 2;
  localparam int VB = 10;

  logic vga_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_next5 = 1'b0;

  vga_pattern_ctrl_if bus ();
  vga_pattern_ctrl_if bus5 ();

  vga_pattern_ctrl #(
    .V_DISP(10'd480), .NUM_PAT(8), .AUTO_FRAMES(12'd3), .INIT_PAT(3'd0)
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .bus(bus)
  );

  vga_pattern_ctrl #(
    .V_DISP(10'd480), .NUM_PAT(5), .AUTO_FRAMES(12'd3), .INIT_PAT(3'd4)
  ) dut5 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .bus(bus5)
  );

  assign bus5.pixel_ypos = bus.pixel_ypos;
  assign bus5.key_next   = key_next5;
  assign bus5.key_mode   = 1'b0;

  always #5 vga_clk = ~vga_clk;

  logic [2:0] exp_q[$];
  logic [2:0] cur_pat    = 3'd0;
  logic       cur_auto   = 1'b0;
  logic       fe_exp     = 1'b0;
  logic       auto_chg   = 1'b0;
  logic       auto_val   = 1'b0;
  logic       mode_target = 1'b0;
  logic [2:0] next_exp   = 3'd0;
  logic [9:0] y_prev     = 10'd0;
  logic       b_arm      = 1'b0;
  int vectors     = 0;
  int miscompares = 0;
  int fe_count    = 0;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, expv);
    end
  endtask

  task automatic check_cycle();
    chk("frame_end", {11'd0, bus.frame_end}, {11'd0, fe_exp});
    if (bus.frame_end === 1'b1) fe_count++;
    if (fe_exp) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL scoreboard_empty t=%0t observed=none expected=entry", $time);
      end else begin
        cur_pat = exp_q.pop_front();
      end
    end
    if (auto_chg) cur_auto = auto_val;
    chk("pat_sel", {9'd0, bus.pat_sel}, {9'd0, cur_pat});
    chk("auto_en", {11'd0, bus.auto_en}, {11'd0, cur_auto});
  endtask

  task automatic tick(input logic [9:0] y, input logic kn, input logic km);
    @(negedge vga_clk);
    check_cycle();
    bus.pixel_ypos = y;
    bus.key_next   = kn;
    bus.key_mode   = km;
    key_next5      = kn & b_arm;
    fe_exp         = (y_prev == 10'd479) && (y == 10'd0);
    if (fe_exp) exp_q.push_back(next_exp);
    auto_chg = km;
    auto_val = mode_target;
    y_prev   = y;
  endtask

  // One frame: lines 0..479 then vertical blanking; line 480 in kn_line/mode_line means
  // the boundary cycle itself.
  task automatic run_frame(input logic [2:0] exp_after, input int kn_line, input int kn_cnt,
                           input int mode_line, input logic mode_to);
    next_exp    = exp_after;
    mode_target = mode_to;
    for (int l = 0; l < 480; l++) begin
      for (int h = 0; h < H; h++) begin
        tick(10'(l),
             (kn_line >= 0) && (kn_line < 480) && (l >= kn_line) && (l < kn_line + kn_cnt) && (h == 0),
             (mode_line == l) && (h == 0));
      end
    end
    for (int b = 0; b < VB; b++) begin
      for (int h = 0; h < H; h++) begin
        tick(10'd0, (kn_line == 480) && (b == 0) && (h == 0),
             (mode_line == 480) && (b == 0) && (h == 0));
      end
    end
  endtask

  initial begin
    bus.pixel_ypos = 10'd0;
    bus.key_next   = 1'b0;
    bus.key_mode   = 1'b0;
    repeat (2) @(negedge vga_clk);
    chk("rst_pat", {9'd0, bus.pat_sel}, 12'd0);
    chk("rst_auto", {11'd0, bus.auto_en}, 12'd0);
    chk("rst_fe", {11'd0, bus.frame_end}, 12'd0);
    chk("rst_pat5", {9'd0, bus5.pat_sel}, 12'd4);
    sys_rst_n = 1'b1;

    // Idle frames: no change, one frame_end per boundary.
    run_frame(3'd0, -1, 0, -1, 1'b0);
    run_frame(3'd0, -1, 0, -1, 1'b0);
    run_frame(3'd0, -1, 0, -1, 1'b0);
    chk("fe_count_idle", 12'(fe_count), 12'd3);

    // Manual: four presses merge into one advance; next frame holds.
    run_frame(3'd1, 100, 4, -1, 1'b0);
    run_frame(3'd1, -1, 0, -1, 1'b0);
    run_frame(3'd2, 300, 1, -1, 1'b0);
    run_frame(3'd3, 480, 1, -1, 1'b0);
    run_frame(3'd4, 0, 1, -1, 1'b0);
    run_frame(3'd5, 479, 1, -1, 1'b0);
    run_frame(3'd6, 200, 2, -1, 1'b0);
    run_frame(3'd7, 10, 1, -1, 1'b0);

    // Wrap on both instances: 7->0 with eight patterns, 4->0 with five.
    chk("pat5_pre_wrap", {9'd0, bus5.pat_sel}, 12'd4);
    b_arm = 1'b1;
    run_frame(3'd0, 240, 1, -1, 1'b0);
    b_arm = 1'b0;
    chk("pat5_wrap", {9'd0, bus5.pat_sel}, 12'd0);

    // Auto mode with a three-frame period, entered mid-frame.
    run_frame(3'd0, -1, 0, 50, 1'b1);
    run_frame(3'd0, -1, 0, -1, 1'b1);
    run_frame(3'd1, -1, 0, -1, 1'b1);
    run_frame(3'd1, -1, 0, -1, 1'b1);
    run_frame(3'd1, -1, 0, -1, 1'b1);
    run_frame(3'd2, -1, 0, -1, 1'b1);
    run_frame(3'd2, -1, 0, -1, 1'b1);
    run_frame(3'd2, -1, 0, -1, 1'b1);
    run_frame(3'd3, -1, 0, -1, 1'b1);
    // Manual press restarts the auto period.
    run_frame(3'd4, 150, 1, -1, 1'b1);
    run_frame(3'd4, -1, 0, -1, 1'b1);
    run_frame(3'd4, -1, 0, -1, 1'b1);
    run_frame(3'd5, -1, 0, -1, 1'b1);

    // Press at auto expiry gives exactly one step.
    run_frame(3'd5, -1, 0, -1, 1'b1);
    run_frame(3'd5, -1, 0, -1, 1'b1);
    run_frame(3'd6, 400, 1, -1, 1'b1);

    // Mode toggle in the expiry boundary cycle: advance, then back to manual and hold.
    run_frame(3'd6, -1, 0, -1, 1'b1);
    run_frame(3'd6, -1, 0, -1, 1'b1);
    run_frame(3'd7, -1, 0, 480, 1'b0);
    run_frame(3'd7, -1, 0, -1, 1'b0);
    run_frame(3'd7, -1, 0, -1, 1'b0);
    run_frame(3'd7, -1, 0, -1, 1'b0);
    run_frame(3'd7, -1, 0, -1, 1'b0);

    // Mid-frame reset with auto on and a request pending.
    mode_target = 1'b1;
    for (int l = 0; l < 200; l++) begin
      for (int h = 0; h < H; h++) tick(10'(l), (l == 100) && (h == 0), (l == 50) && (h == 0));
    end
    @(negedge vga_clk);
    check_cycle();
    chk("pre_rst_auto", {11'd0, bus.auto_en}, 12'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_pat", {9'd0, bus.pat_sel}, 12'd0);
    chk("async_rst_auto", {11'd0, bus.auto_en}, 12'd0);
    chk("async_rst_fe", {11'd0, bus.frame_end}, 12'd0);
    chk("async_rst_pat5", {9'd0, bus5.pat_sel}, 12'd4);
    bus.pixel_ypos = 10'd0;
    bus.key_next   = 1'b0;
    bus.key_mode   = 1'b0;
    repeat (3) @(negedge vga_clk);
    sys_rst_n = 1'b1;
    cur_pat  = 3'd0;
    cur_auto = 1'b0;
    fe_exp   = 1'b0;
    auto_chg = 1'b0;
    y_prev   = 10'd0;
    exp_q.delete();

    // First boundary after reset must not advance; later presses still work.
    run_frame(3'd0, -1, 0, -1, 1'b0);
    run_frame(3'd1, 60, 1, -1, 1'b0);
    chk("sb_drained", 12'(exp_q.size()), 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
